// File: rtl/mdu_ctrl_pkg.sv
// Shared constants for the multiply/divide unit: op encodings, default latencies, FSM states.
// Divide support is controlled by the MDU_DIV_EN macro.
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // Ops that occupy the unit for multiple cycles and therefore can stall D.
    function automatic logic is_multicycle(input logic [2:0] op);
`ifdef MDU_DIV_EN
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`else
        return (op == MD_MULT) || (op == MD_MULTU);
`endif
    endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller with HI/LO registers and fixed-latency pipeline model.
// Define MDU_DIV_EN to build DIV/DIVU; otherwise they are treated as no-ops.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;

    assign prod_s = $signed(rs_val) * $signed(rt_val);
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

`ifdef MDU_DIV_EN
    logic        div_zero;
    logic [31:0] rt_safe;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;

    // Substitute a divisor of 1 so the arithmetic never sees zero; the result is discarded anyway.
    assign div_zero = (rt_val == '0);
    assign rt_safe  = div_zero ? 32'd1 : rt_val;
    assign quo_s    = $signed(rs_val) / $signed(rt_safe);
    assign rem_s    = $signed(rs_val) % $signed(rt_safe);
    assign quo_u    = rs_val / rt_safe;
    assign rem_u    = rs_val % rt_safe;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (md_op_e'(md_op))
                        MD_MULT: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            pend_wr_d = 1'b1;
                            cnt_d     = 4'(MULT_LAT);
                            state_d   = ST_BUSY;
                        end
                        MD_MULTU: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            pend_wr_d = 1'b1;
                            cnt_d     = 4'(MULT_LAT);
                            state_d   = ST_BUSY;
                        end
`ifdef MDU_DIV_EN
                        MD_DIV: begin
                            pend_hi_d = rem_s;
                            pend_lo_d = quo_s;
                            pend_wr_d = !div_zero;
                            cnt_d     = 4'(DIV_LAT);
                            state_d   = ST_BUSY;
                        end
                        MD_DIVU: begin
                            pend_hi_d = rem_u;
                            pend_lo_d = quo_u;
                            pend_wr_d = !div_zero;
                            cnt_d     = 4'(DIV_LAT);
                            state_d   = ST_BUSY;
                        end
`endif
                        MD_MTHI: hi_d = rs_val;
                        MD_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q == ST_BUSY);
    assign stall_req = d_is_md & (busy | (start & is_multicycle(md_op)));
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl; DIV expectations follow the MDU_DIV_EN macro.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        d_is_md = 1'b0;
    logic        busy, stall_req, done;
    logic [31:0] hi, lo;

    int n_chk = 0;
    int n_fail = 0;

    mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .d_is_md(d_is_md),
        .busy(busy), .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Issue one op at the next edge, then watch busy/stall/done until it drops (bounded).
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input bit inject);
        int cycles;
        logic [31:0] hi_before;
        hi_before = hi;
        @(negedge clk);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        #1 check({tag, ".stall_at_start"}, 32'(stall_req), 32'(lat > 0));
        @(negedge clk);
        start  = 1'b0;
        rs_val = 32'h5A5A_0001;
        rt_val = 32'h0000_0003;
        cycles = 0;
        while (busy && cycles < 40) begin
            check({tag, ".stall_busy"}, 32'(stall_req), 32'd1);
            check({tag, ".done_busy"}, 32'(done), 32'd0);
            if (inject && cycles == 2) check({tag, ".mthi_ignored"}, hi, hi_before);
            if (inject && cycles == 1) begin
                start  = 1'b1;
                md_op  = MD_MTHI;
                rs_val = 32'h0000_1234;
            end else begin
                start = 1'b0;
            end
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, ".busy_cycles"}, 32'(cycles), 32'(lat));
        check({tag, ".done"}, 32'(done), 32'(lat > 0));
        check({tag, ".stall_after"}, 32'(stall_req), 32'd0);
        @(negedge clk);
        check({tag, ".done_pulse_end"}, 32'(done), 32'd0);
    endtask

    initial begin
        d_is_md = 1'b1;
        #12;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.hi", hi, 32'd0);
        check("rst.lo", lo, 32'd0);
        check("rst.stall", 32'(stall_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mult", MD_MULT, 32'hFFFF_FFFF, 32'd2, 5, 1'b1);
        check("mult.hi", hi, 32'hFFFF_FFFF);
        check("mult.lo", lo, 32'hFFFF_FFFE);

        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 1'b0);
        check("multu.hi", hi, 32'h0000_0001);
        check("multu.lo", lo, 32'hFFFF_FFFE);

        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd5, 5, 1'b0);
        check("mult_neg.hi", hi, 32'hFFFF_FFFF);
        check("mult_neg.lo", lo, 32'hFFFF_FFF1);

        run_op("mthi", MD_MTHI, 32'h0000_1234, 32'd0, 0, 1'b0);
        check("mthi.hi", hi, 32'h0000_1234);
        check("mthi.lo", lo, 32'hFFFF_FFF1);
        check("mthi.busy", 32'(busy), 32'd0);

        run_op("mtlo", MD_MTLO, 32'h0000_ABCD, 32'd0, 0, 1'b0);
        check("mtlo.hi", hi, 32'h0000_1234);
        check("mtlo.lo", lo, 32'h0000_ABCD);

`ifdef MDU_DIV_EN
        run_op("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 1'b0);
        check("div.hi", hi, 32'hFFFF_FFFF);
        check("div.lo", lo, 32'hFFFF_FFFD);
        run_op("divu0", MD_DIVU, 32'd7, 32'd0, 10, 1'b0);
        check("divu0.hi", hi, 32'hFFFF_FFFF);
        check("divu0.lo", lo, 32'hFFFF_FFFD);
        run_op("divu", MD_DIVU, 32'd100, 32'd7, 10, 1'b0);
        check("divu.hi", hi, 32'd2);
        check("divu.lo", lo, 32'd14);
`else
        run_op("div_off", MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        check("div_off.hi", hi, 32'h0000_1234);
        check("div_off.lo", lo, 32'h0000_ABCD);
        run_op("divu_off", MD_DIVU, 32'd7, 32'd0, 0, 1'b0);
        check("divu_off.hi", hi, 32'h0000_1234);
        check("divu_off.lo", lo, 32'h0000_ABCD);
`endif

        run_op("noop", 3'd6, 32'hDEAD_BEEF, 32'd9, 0, 1'b0);

        // Reset in the third busy cycle of a MULT must abort without commit.
        @(negedge clk);
        start  = 1'b1;
        md_op  = MD_MULT;
        rs_val = 32'd3;
        rt_val = 32'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort.busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.hi", hi, 32'd0);
        check("abort.lo", lo, 32'd0);
        check("abort.done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort.no_done", 32'(done), 32'd0);
        end
        check("abort.lo_after", lo, 32'd0);

        run_op("post_rst", MD_MULT, 32'd3, 32'd4, 5, 1'b0);
        check("post_rst.hi", hi, 32'd0);
        check("post_rst.lo", lo, 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state changes on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: start  in  1  E-stage MDU instruction valid this cycle.
REQ-004 SHALL have ports: md_op  in  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO; other codes no-op.
REQ-005 SHALL have ports: rs_val  in  32  forwarded GPR[rs] operand.
REQ-006 SHALL have ports: rt_val  in  32  forwarded GPR[rt] operand.
REQ-007 SHALL have ports: d_is_md  in  1  D-stage instruction is MDU-class: mult/div/mthi/mtlo/mfhi/mflo.
REQ-008 SHALL have ports: busy  out  1  multi-cycle operation in progress.
REQ-009 SHALL have ports: stall_req  out  1  hold D stage.
REQ-010 SHALL have ports: done  out  1  one-cycle pulse when HI/LO committed by mult/div.
REQ-011 SHALL have ports: hi  out  32  HI register.
REQ-012 SHALL have ports: lo  out  32  LO register.
REQ-013 SHALL have parameters: MULT_LAT, default 5, mult cycles; DIV_LAT, default 10, div cycles (both 1..15).

Function
REQ-014 SHALL be a two-state FSM, IDLE and BUSY, with a 4-bit down-counter cnt.
REQ-015 IDLE, start=1, op MULT/MULTU at edge k: SHALL compute 64-bit product (signed/unsigned per op) into pend_hi/pend_lo, load cnt=MULT_LAT, go BUSY.
REQ-016 IDLE, start=1, op DIV/DIVU: SHALL latch pend_lo=quotient, pend_hi=remainder (signed truncates toward zero, remainder takes dividend sign), cnt=DIV_LAT, go BUSY.
REQ-017 Divisor zero: SHALL still run DIV_LAT cycles, then leave hi/lo unchanged; done still pulses.
REQ-018 IDLE, start=1, MTHI/MTLO: SHALL write rs_val to hi/lo at that edge; no BUSY, no done.
REQ-019 BUSY: SHALL decrement cnt each edge; on edge where cnt==1 SHALL commit pend_hi/pend_lo to hi/lo, cnt->0, go IDLE, done=1 for the following cycle.
REQ-020 busy SHALL equal (state==BUSY), registered; high exactly MULT_LAT/DIV_LAT cycles after start edge.
REQ-021 stall_req SHALL equal d_is_md & (busy | (start & op is mult/div)), combinational.
REQ-022 start while BUSY (any op) SHALL be ignored; hi/lo/counter unaffected.
REQ-023 Operands SHALL be sampled only at the start edge; later rs_val/rt_val changes SHALL not affect the result.
REQ-024 hi/lo SHALL be read combinationally from registers, no bypass of pending result.

Reset
REQ-025 rst_n low SHALL asynchronously force state=IDLE, cnt=0, busy=0, done=0, hi=0, lo=0, pending=0.
REQ-026 Reset mid-operation SHALL abort without committing; first start after release behaves as from IDLE.

Configuration
REQ-027 Macro MDU_DIV_EN defined: DIV/DIVU SHALL be implemented per REQ-016/017.
REQ-028 MDU_DIV_EN undefined: DIV/DIVU SHALL be no-ops (no BUSY, no stall, hi/lo unchanged); divider logic SHALL not be synthesised.

Structure
REQ-029 md_op encodings, MULT_LAT/DIV_LAT defaults and FSM state codes SHALL live in shared constants.v alongside existing ALU/CMP macros.
REQ-030 No sub-module; single flat module with inline arithmetic.

Verification
REQ-031 MULT rs=0xFFFFFFFF, rt=2 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE, done 1 cycle.
REQ-032 MULTU rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
REQ-033 DIV rs=-7, rt=2 (MDU_DIV_EN) -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> hi/lo unchanged, done pulses.
REQ-034 MTHI rs=0x1234 while BUSY -> ignored; MTHI in IDLE -> hi=0x1234 next cycle, busy stays 0.
REQ-035 d_is_md=1 during BUSY -> stall_req=1 every busy cycle, 0 the cycle after commit.
REQ-036 rst_n low at cycle 3 of MULT -> busy=0, hi=lo=0 immediately, no done.
